// File: rtl/audio_codec_i2c_axil_pkg.sv
// Shared constants, FSM state types and helpers for the audio codec I2C AXI4-Lite register bank.
package audio_codec_i2c_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte address bits below this index select a byte inside a 32-bit word.
    localparam int REG_IDX_LSB = 2;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_WAIT_D = 2'd1,
        W_WAIT_A = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/audio_codec_i2c_axil_wr_ch.sv
// Write channel of the register bank: accepts AW and W in either order, latches whichever
// arrives first, signals a one-cycle commit to the top and drives the B channel.
module audio_codec_i2c_axil_wr_ch
    import audio_codec_i2c_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                              clk,
    input  logic                              areset,
    input  logic [ADDR_WIDTH-1:0]             awaddr,
    input  logic                              awvalid,
    output logic                              awready,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [DATA_WIDTH/8-1:0]           wstrb,
    input  logic                              wvalid,
    output logic                              wready,
    output logic [1:0]                        bresp,
    output logic                              bvalid,
    input  logic                              bready,
    output logic                              commit,
    output logic [ADDR_WIDTH-1:REG_IDX_LSB]   idx,
    output logic [DATA_WIDTH-1:0]             data,
    output logic [DATA_WIDTH/8-1:0]           strb,
    output wr_state_t                         state
);

    wr_state_t                 state_q;
    wr_state_t                 state_d;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH/8-1:0]   strb_q;
    logic [ADDR_WIDTH-1:0]     addr_sel;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      unused;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = W_RESP;
                end else if (aw_hs) begin
                    state_d = W_WAIT_D;
                end else if (w_hs) begin
                    state_d = W_WAIT_A;
                end
            end
            W_WAIT_D: if (w_hs) state_d = W_RESP;
            W_WAIT_A: if (aw_hs) state_d = W_RESP;
            W_RESP:   if (bvalid && bready) state_d = W_IDLE;
            default:  state_d = W_IDLE;
        endcase
    end

    // The commit cycle is the one whose edge moves the FSM into W_RESP; live channel
    // values win over the latched copy because they complete the pair on this cycle.
    assign commit   = !areset && (state_q != W_RESP) && (state_d == W_RESP);
    assign addr_sel = aw_hs ? awaddr : addr_q;
    assign data     = w_hs ? wdata : data_q;
    assign strb     = w_hs ? wstrb : strb_q;
    assign idx      = addr_sel[ADDR_WIDTH-1:REG_IDX_LSB];
    assign state    = state_q;
    assign unused   = ^addr_sel[REG_IDX_LSB-1:0];

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            awready <= (state_d == W_IDLE) || (state_d == W_WAIT_A);
            wready  <= (state_d == W_IDLE) || (state_d == W_WAIT_D);
            bvalid  <= (state_d == W_RESP);
            if (aw_hs) begin
                addr_q <= awaddr;
            end
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (commit) begin
                bresp <= idx_in_range(32'(idx), NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: rtl/audio_codec_i2c_axil_slave.sv
// AXI4-Lite register bank for the audio codec I2C controller: NUM_REGS read/write words,
// exported flat with per-register write pulses. Define AUDIO_CODEC_I2C_AXIL_WSTRB_EN for byte-lane writes.
module audio_codec_i2c_axil_slave
    import audio_codec_i2c_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] regs_o,
    output logic [NUM_REGS-1:0]                    reg_wr_o
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = AW - REG_IDX_LSB;

    logic [DW-1:0]            regs [NUM_REGS];
    logic                     wr_commit;
    logic [AW-1:REG_IDX_LSB]  wr_idx;
    logic [DW-1:0]            wr_data;
    logic [DW/8-1:0]          wr_strb;
    wr_state_t                wr_state;
    rd_state_t                rd_state;
    logic                     ar_hs;
    logic [AW-1:REG_IDX_LSB]  rd_idx;
    logic [DW-1:0]            rd_word;
    logic                     unused;

    audio_codec_i2c_axil_wr_ch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_ch (
        .clk     (ACLK),
        .areset  (ARESET),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .commit  (wr_commit),
        .idx     (wr_idx),
        .data    (wr_data),
        .strb    (wr_strb),
        .state   (wr_state)
    );

    // Out-of-range commits match no k, so they are dropped without a pulse.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_idx == IDX_W'(k)) begin
`ifdef AUDIO_CODEC_I2C_AXIL_WSTRB_EN
                    for (int b = 0; b < DW/8; b++) begin
                        if (wr_strb[b]) begin
                            regs[k][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
`else
                    regs[k] <= wr_data;
`endif
                end
            end
        end
    end

    always_comb begin
        reg_wr_o = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_commit && (wr_idx == IDX_W'(k))) begin
                reg_wr_o[k] = 1'b1;
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_o[DW*k +: DW] = regs[k];
        end
    end

    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign rd_idx = S_AXI_ARADDR[AW-1:REG_IDX_LSB];

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_word = regs[k];
            end
        end
    end

    // The read samples regs before any same-edge commit lands, so it returns the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state      <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_hs) begin
                        rd_state      <= R_DATA;
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= rd_word;
                        S_AXI_RRESP   <= idx_in_range(32'(rd_idx), NUM_REGS) ? RESP_OKAY
                                                                             : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rd_state      <= R_IDLE;
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

`ifdef AUDIO_CODEC_I2C_AXIL_WSTRB_EN
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[REG_IDX_LSB-1:0], wr_state};
`else
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[REG_IDX_LSB-1:0], wr_state, wr_strb};
`endif

endmodule
